cpu_csr_irq: RTL and testbench
==============================

Name: cpu_csr_irq

Overview:
- Next-generation machine-mode CSR/trap unit for the Rv32 pipeline. Sits in the execute stage beside the ALU and is driven by decoded CSR/MRET requests.
- Adds over the previous generation: a parametrised number of local interrupt lines, an external interrupt, mstatus MIE/MPIE nesting, MRET, vectored mtvec, mscratch, and mcycle/minstret counters.
- Produces a read value for rd writeback and a branch redirect on trap entry or MRET.

Parameters:
- NUM_IRQ, 4: local interrupt lines (1..16), mapped to mip/mie bits 16..16+NUM_IRQ-1.
- COUNTER_WIDTH, 64: implemented width of mcycle/minstret (32..64). Unimplemented upper bits read 0.
- MTVEC_RESET, 32'h00000000: mtvec value after reset.
- HART_ID, 0: value returned by mhartid.

Ports:
- i_clock, input, 1: clock, rising edge.
- i_reset, input, 1: asynchronous, active-low reset (asserted when 0).
- i_ext_irq, input, 1: level external interrupt, drives MEIP (bit 11).
- i_timer_irq, input, 1: level timer interrupt, drives MTIP (bit 7).
- i_irq, input, NUM_IRQ: level local interrupts.
- i_retire, input, 1: one instruction retired this cycle.
- i_request, input, 1: execute-stage slot valid.
- i_pc, input, 32: PC of the requesting instruction.
- i_op, input, 3: 0=none/plain, 1=CSRRW, 2=CSRRS, 3=CSRRC, 4=MRET, 5=CSRRWI, 6=CSRRSI, 7=CSRRCI.
- i_addr, input, 12: CSR address.
- i_rs1, input, 32: register operand.
- i_zimm, input, 5: immediate operand, zero-extended.
- i_inst_rd, input, 5: destination register.
- o_ready, output, 1: one-cycle pulse, result valid.
- o_inst_rd, output, 5: destination register; 0 suppresses writeback.
- o_rd, output, 32: old CSR value.
- o_branch, output, 1: one-cycle redirect pulse.
- o_branch_pc, output, 32: redirect target.

Behaviour:
- Reset:
  - All outputs 0.
  - mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mscratch=0; counters=0; mtvec=MTVEC_RESET.
- Latency:
  - Request sampled at edge N; o_ready, o_rd, o_inst_rd, o_branch and o_branch_pc valid in cycle N+1.
  - Back-to-back requests are accepted every cycle; there is no stall.
- mip is live, registered one cycle from the irq inputs, and read-only. Writes to mip and misa are ignored.
- Interrupt taken when all hold: i_request=1, mstatus.MIE=1, and (mip & mie) != 0.
  - Priority: MEI(11) > MTI(7) > local, lowest index first.
  - Actions: mepc<=i_pc; mcause<={1'b1, cause}; MPIE<=MIE; MIE<=0; o_branch=1; o_ready=1; o_inst_rd=0.
  - The requesting instruction (including a CSR op or MRET) is not executed.
  - Target: mtvec[1:0]==0 gives {mtvec[31:2],2'b00}; ==1 gives base + 4*cause.
- CSR op, no trap:
  - o_rd = old value; o_inst_rd = i_inst_rd.
  - New value: W = operand; S = old|operand; C = old&~operand. Operand is i_rs1, or i_zimm for ops 5..7.
  - S/C with operand 0 performs no write.
- MRET: MIE<=MPIE; MPIE<=1; o_branch=1; o_branch_pc=mepc; o_inst_rd=0.
- Addresses:
  - mstatus 0x300: only bit 3 (MIE) and bit 7 (MPIE) are writable.
  - misa 0x301: reads 0x40000100.
  - mie 0x304: writable bits 11, 7, 16..16+NUM_IRQ-1.
  - mtvec 0x305: bit 1 is forced to 0.
  - mscratch 0x340: fully writable.
  - mepc 0x341: bits[1:0] forced to 0.
  - mcause 0x342: fully writable.
  - mip 0x344: read-only.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82.
  - mhartid 0xF14; mvendorid, marchid and mimpid read 0.
  - Unknown addresses read 0 and ignore writes.
- Counters:
  - mcycle increments every cycle; minstret increments when i_retire=1.
  - Both wrap modulo 2^COUNTER_WIDTH.
  - A CSR write to a counter half in the same cycle overrides that cycle's increment for the whole counter.
- Reset mid-operation: outputs clear immediately and asynchronously; a pending o_ready/o_branch pulse is dropped.

Test Plan:
- Reset release, then read mtvec, misa and mhartid -> o_rd = MTVEC_RESET, 0x40000100, HART_ID; o_ready pulses exactly 1 cycle after each request.
- CSRRW mscratch with rs1=0xDEADBEEF, then CSRRS with rs1=0x0000FFFF, then CSRRCI with zimm=0x0F -> o_rd = 0, 0xDEADBEEF, 0xDEADFFFF; final value 0xDEADFFF0.
- mtvec=0x1001, mie=0x880, MIE=1; assert i_ext_irq and i_timer_irq, then issue a request at pc 0x200 -> o_branch_pc=0x102C, mcause=0x8000000B, mepc=0x200, MIE=0, MPIE=1, o_inst_rd=0.
- MRET after the previous scenario -> o_branch_pc=0x200, MIE=1, MPIE=1; with i_timer_irq still high, the next request traps to 0x101C with cause 7.
- Set mcycle=0xFFFFFFFF (COUNTER_WIDTH=64), then idle 2 cycles -> mcycleh reads 1; 5 i_retire pulses -> minstret increases by 5; a write-in-same-cycle increment is lost.
- Local irq[2] with mie bit 18 set, MIE=0 -> no trap and mip reads 0x40000; setting MIE=1 -> trap with mcause=0x80000012.

Source files
------------

// File: rtl/cpu_csr_irq.sv
// Machine-mode CSR file and trap unit: CSR read/modify/write, interrupt entry,
// MRET, vectored mtvec and mcycle/minstret counters with a one-cycle result.
module cpu_csr_irq #(
  parameter int unsigned NUM_IRQ       = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter int unsigned HART_ID       = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_ext_irq,
  input  logic               i_timer_irq,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_retire,
  input  logic               i_request,
  input  logic [31:0]        i_pc,
  input  logic [2:0]         i_op,
  input  logic [11:0]        i_addr,
  input  logic [31:0]        i_rs1,
  input  logic [4:0]         i_zimm,
  input  logic [4:0]         i_inst_rd,
  output logic               o_ready,
  output logic [4:0]         o_inst_rd,
  output logic [31:0]        o_rd,
  output logic               o_branch,
  output logic [31:0]        o_branch_pc
);

  localparam logic [2:0] OP_MRET = 3'd4;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0880 |
                                       (((32'd1 << NUM_IRQ) - 32'd1) << 16);

  logic                     mstatus_mie_q, mstatus_mie_d;
  logic                     mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0]              irq_enable_q, irq_enable_d;
  logic [31:0]              mip_q, mip_d;
  logic [31:0]              mtvec_q, mtvec_d;
  logic [31:0]              mscratch_q, mscratch_d;
  logic [31:0]              mepc_q, mepc_d;
  logic [31:0]              mcause_q, mcause_d;
  logic [COUNTER_WIDTH-1:0] mcycle_q, mcycle_d;
  logic [COUNTER_WIDTH-1:0] minstret_q, minstret_d;

  logic                     ready_q, ready_d;
  logic [4:0]               inst_rd_q, inst_rd_d;
  logic [31:0]              rd_q, rd_d;
  logic                     branch_q, branch_d;
  logic [31:0]              branch_pc_q, branch_pc_d;

  logic [31:0] pending;
  logic        trap_take;
  logic [4:0]  trap_cause;
  logic [31:0] trap_base;
  logic [31:0] trap_target;
  logic [63:0] cycle64;
  logic [63:0] instret64;
  logic [31:0] csr_rdata;
  logic [31:0] operand;
  logic [31:0] csr_wdata;
  logic        is_csr;
  logic        csr_we;
  logic        do_mret;

  // Interrupt arbitration: MEI beats MTI beats local lines, lowest local index first.
  always_comb begin
    pending    = mip_q & irq_enable_q;
    trap_take  = i_request && mstatus_mie_q && (pending != 32'd0);
    trap_cause = 5'd0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pending[16 + i]) trap_cause = 5'(16 + i);
    end
    if (pending[7])  trap_cause = 5'd7;
    if (pending[11]) trap_cause = 5'd11;
    trap_base   = {mtvec_q[31:2], 2'b00};
    trap_target = (mtvec_q[1:0] == 2'b01) ? trap_base + {25'd0, trap_cause, 2'b00}
                                          : trap_base;
  end

  always_comb begin
    cycle64   = 64'(mcycle_q);
    instret64 = 64'(minstret_q);
    csr_rdata = 32'd0;
    case (i_addr)
      ADDR_MSTATUS:   csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      ADDR_MISA:      csr_rdata = MISA_VALUE;
      ADDR_MIE:       csr_rdata = irq_enable_q;
      ADDR_MTVEC:     csr_rdata = mtvec_q;
      ADDR_MSCRATCH:  csr_rdata = mscratch_q;
      ADDR_MEPC:      csr_rdata = mepc_q;
      ADDR_MCAUSE:    csr_rdata = mcause_q;
      ADDR_MIP:       csr_rdata = mip_q;
      ADDR_MCYCLE:    csr_rdata = cycle64[31:0];
      ADDR_MCYCLEH:   csr_rdata = cycle64[63:32];
      ADDR_MINSTRET:  csr_rdata = instret64[31:0];
      ADDR_MINSTRETH: csr_rdata = instret64[63:32];
      ADDR_MHARTID:   csr_rdata = 32'(HART_ID);
      default:        csr_rdata = 32'd0;
    endcase
  end

  // op[1:0] selects write/set/clear; op[2] with a nonzero low pair picks the immediate.
  always_comb begin
    is_csr  = (i_op[1:0] != 2'b00);
    operand = (i_op[2] && is_csr) ? {27'd0, i_zimm} : i_rs1;
    case (i_op[1:0])
      2'b01:   csr_wdata = operand;
      2'b10:   csr_wdata = csr_rdata | operand;
      2'b11:   csr_wdata = csr_rdata & ~operand;
      default: csr_wdata = csr_rdata;
    endcase
    csr_we  = i_request && !trap_take && is_csr &&
              ((i_op[1:0] == 2'b01) || (operand != 32'd0));
    do_mret = i_request && !trap_take && (i_op == OP_MRET);
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    irq_enable_d   = irq_enable_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + COUNTER_WIDTH'(1);
    minstret_d     = i_retire ? minstret_q + COUNTER_WIDTH'(1) : minstret_q;

    mip_d                  = 32'd0;
    mip_d[11]              = i_ext_irq;
    mip_d[7]               = i_timer_irq;
    mip_d[16 +: NUM_IRQ]   = i_irq;

    // A write to either counter half replaces the whole counter for this cycle.
    if (csr_we) begin
      case (i_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata[3];
          mstatus_mpie_d = csr_wdata[7];
        end
        ADDR_MIE:       irq_enable_d = csr_wdata & MIE_MASK;
        ADDR_MTVEC:     mtvec_d      = {csr_wdata[31:2], 1'b0, csr_wdata[0]};
        ADDR_MSCRATCH:  mscratch_d   = csr_wdata;
        ADDR_MEPC:      mepc_d       = {csr_wdata[31:2], 2'b00};
        ADDR_MCAUSE:    mcause_d     = csr_wdata;
        ADDR_MCYCLE:    mcycle_d     = COUNTER_WIDTH'({cycle64[63:32], csr_wdata});
        ADDR_MCYCLEH:   mcycle_d     = COUNTER_WIDTH'({csr_wdata, cycle64[31:0]});
        ADDR_MINSTRET:  minstret_d   = COUNTER_WIDTH'({instret64[63:32], csr_wdata});
        ADDR_MINSTRETH: minstret_d   = COUNTER_WIDTH'({csr_wdata, instret64[31:0]});
        default: ;
      endcase
    end

    if (trap_take) begin
      mepc_d         = i_pc;
      mcause_d       = {1'b1, 26'd0, trap_cause};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (do_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_comb begin
    ready_d     = i_request;
    inst_rd_d   = 5'd0;
    rd_d        = 32'd0;
    branch_d    = 1'b0;
    branch_pc_d = 32'd0;
    if (trap_take) begin
      branch_d    = 1'b1;
      branch_pc_d = trap_target;
    end else if (do_mret) begin
      branch_d    = 1'b1;
      branch_pc_d = mepc_q;
    end else if (i_request && is_csr) begin
      rd_d      = csr_rdata;
      inst_rd_d = i_inst_rd;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      irq_enable_q   <= 32'd0;
      mip_q          <= 32'd0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      ready_q        <= 1'b0;
      inst_rd_q      <= 5'd0;
      rd_q           <= 32'd0;
      branch_q       <= 1'b0;
      branch_pc_q    <= 32'd0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      irq_enable_q   <= irq_enable_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      ready_q        <= ready_d;
      inst_rd_q      <= inst_rd_d;
      rd_q           <= rd_d;
      branch_q       <= branch_d;
      branch_pc_q    <= branch_pc_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_inst_rd   = inst_rd_q;
  assign o_rd        = rd_q;
  assign o_branch    = branch_q;
  assign o_branch_pc = branch_pc_q;

endmodule

// File: tb/tb_cpu_csr_irq.sv
// Directed bench for cpu_csr_irq: every driven cycle queues its expected result,
// which is popped and compared on the following falling edge.
module tb_cpu_csr_irq;

  localparam logic [2:0] OP_NONE = 3'd0, OP_RW = 3'd1, OP_RS = 3'd2, OP_RC = 3'd3;
  localparam logic [2:0] OP_MRET = 3'd4, OP_RWI = 3'd5, OP_RSI = 3'd6, OP_RCI = 3'd7;

  localparam logic [11:0] MSTATUS = 12'h300, MISA = 12'h301, MIE = 12'h304, MTVEC = 12'h305;
  localparam logic [11:0] MSCRATCH = 12'h340, MEPC = 12'h341, MCAUSE = 12'h342, MIP = 12'h344;
  localparam logic [11:0] MCYCLE = 12'hB00, MINSTRET = 12'hB02, MCYCLEH = 12'hB80;
  localparam logic [11:0] MINSTRETH = 12'hB82, MHARTID = 12'hF14, MVENDORID = 12'hF11;

  logic        clk = 1'b0;
  logic        i_reset, i_ext_irq, i_timer_irq, i_retire, i_request;
  logic [3:0]  i_irq;
  logic [31:0] i_pc, i_rs1;
  logic [2:0]  i_op;
  logic [11:0] i_addr;
  logic [4:0]  i_zimm, i_inst_rd;
  logic        o_ready, o_branch;
  logic [4:0]  o_inst_rd;
  logic [31:0] o_rd, o_branch_pc;

  typedef struct packed {
    logic        ready;
    logic        branch;
    logic [4:0]  inst_rd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        chk_pc;
    logic [31:0] pc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_tag;
  logic  mon_en = 1'b0;
  int    checks = 0;
  int    failures = 0;

  cpu_csr_irq #(
    .NUM_IRQ(4), .COUNTER_WIDTH(64), .MTVEC_RESET(32'h0000_0100), .HART_ID(3)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_ext_irq(i_ext_irq), .i_timer_irq(i_timer_irq),
    .i_irq(i_irq), .i_retire(i_retire), .i_request(i_request), .i_pc(i_pc),
    .i_op(i_op), .i_addr(i_addr), .i_rs1(i_rs1), .i_zimm(i_zimm), .i_inst_rd(i_inst_rd),
    .o_ready(o_ready), .o_inst_rd(o_inst_rd), .o_rd(o_rd), .o_branch(o_branch),
    .o_branch_pc(o_branch_pc)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one entry per driven cycle, so latency is checked exactly.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        mon_e   = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        check_output({mon_tag, ".ready"}, 32'(o_ready), 32'(mon_e.ready));
        check_output({mon_tag, ".branch"}, 32'(o_branch), 32'(mon_e.branch));
        if (mon_e.ready) check_output({mon_tag, ".inst_rd"}, 32'(o_inst_rd), 32'(mon_e.inst_rd));
        if (mon_e.chk_rd) check_output({mon_tag, ".rd"}, o_rd, mon_e.rd);
        if (mon_e.chk_pc) check_output({mon_tag, ".branch_pc"}, o_branch_pc, mon_e.pc);
      end else begin
        check_output("unexpected.ready", 32'(o_ready), 32'd0);
      end
    end
  end

  function automatic exp_t e_rd(input logic [4:0] rd, input logic [31:0] val);
    exp_t e = '0;
    e.ready = 1'b1; e.inst_rd = rd; e.chk_rd = 1'b1; e.rd = val;
    return e;
  endfunction

  function automatic exp_t e_nochk(input logic [4:0] rd);
    exp_t e = '0;
    e.ready = 1'b1; e.inst_rd = rd;
    return e;
  endfunction

  function automatic exp_t e_br(input logic [31:0] target);
    exp_t e = '0;
    e.ready = 1'b1; e.branch = 1'b1; e.chk_pc = 1'b1; e.pc = target;
    return e;
  endfunction

  task automatic apply_stimulus(input logic req, input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] rs1, input logic [4:0] zimm,
                                input logic [4:0] rd, input logic [31:0] pc,
                                input logic retire, input exp_t e, input string tag);
    @(negedge clk); #1;
    i_request = req; i_op = op; i_addr = addr; i_rs1 = rs1; i_zimm = zimm;
    i_inst_rd = rd; i_pc = pc; i_retire = retire;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Immediate forms get a contradictory rs1 so a wrong operand source shows up.
  task automatic csr_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] opnd,
                        input logic [4:0] rd, input logic [31:0] exp_rd, input string tag);
    apply_stimulus(1'b1, op, addr, op[2] ? 32'hFFFF_FFFF : opnd, opnd[4:0], rd, 32'h0,
                   1'b0, e_rd(rd, exp_rd), tag);
  endtask

  task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp_rd, input string tag);
    csr_op(OP_RS, addr, 32'd0, 5'd1, exp_rd, tag);
  endtask

  task automatic csr_write_nc(input logic [11:0] addr, input logic [31:0] val, input string tag);
    apply_stimulus(1'b1, OP_RW, addr, val, 5'd0, 5'd2, 32'h0, 1'b0, e_nochk(5'd2), tag);
  endtask

  task automatic idle(input int n, input logic retire);
    for (int k = 0; k < n; k++)
      apply_stimulus(1'b0, OP_NONE, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0, retire, exp_t'('0), "idle");
  endtask

  task automatic trap_req(input logic [31:0] pc, input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] rd,
                          input logic [31:0] target, input string tag);
    apply_stimulus(1'b1, op, addr, rs1, 5'd0, rd, pc, 1'b0, e_br(target), tag);
  endtask

  initial begin
    i_reset = 1'b0; i_ext_irq = 1'b0; i_timer_irq = 1'b0; i_irq = 4'd0; i_retire = 1'b0;
    i_request = 1'b0; i_pc = 32'd0; i_op = 3'd0; i_addr = 12'd0; i_rs1 = 32'd0;
    i_zimm = 5'd0; i_inst_rd = 5'd0;
    #2;
    check_output("reset.ready", 32'(o_ready), 32'd0);
    check_output("reset.branch", 32'(o_branch), 32'd0);
    check_output("reset.rd", o_rd, 32'd0);
    check_output("reset.inst_rd", 32'(o_inst_rd), 32'd0);
    check_output("reset.branch_pc", o_branch_pc, 32'd0);
    #20 i_reset = 1'b1;
    $display("[TB] reset released");
    mon_en = 1'b1;

    csr_read(MTVEC, 32'h0000_0100, "mtvec_reset");
    csr_read(MISA, 32'h4000_0100, "misa");
    csr_read(MHARTID, 32'd3, "mhartid");
    csr_read(MVENDORID, 32'd0, "mvendorid");
    csr_op(OP_RW, 12'h7C0, 32'h1234, 5'd4, 32'd0, "unknown_write");
    csr_read(12'h7C0, 32'd0, "unknown_read");

    csr_op(OP_RW, MSCRATCH, 32'hDEAD_BEEF, 5'd5, 32'd0, "mscratch_rw");
    csr_op(OP_RS, MSCRATCH, 32'h0000_FFFF, 5'd6, 32'hDEAD_BEEF, "mscratch_rs");
    csr_op(OP_RCI, MSCRATCH, 32'h0000_000F, 5'd7, 32'hDEAD_FFFF, "mscratch_rci");
    csr_op(OP_RC, MSCRATCH, 32'd0, 5'd8, 32'hDEAD_FFF0, "mscratch_final");

    csr_op(OP_RW, MISA, 32'd0, 5'd3, 32'h4000_0100, "misa_write");
    csr_read(MISA, 32'h4000_0100, "misa_after_write");
    csr_op(OP_RW, MEPC, 32'h0000_1237, 5'd3, 32'd0, "mepc_write");
    csr_read(MEPC, 32'h0000_1234, "mepc_align");
    csr_op(OP_RW, MSTATUS, 32'hFFFF_FFFF, 5'd3, 32'd0, "mstatus_write");
    csr_op(OP_RW, MSTATUS, 32'd0, 5'd3, 32'h0000_0088, "mstatus_mask");
    csr_read(MSTATUS, 32'd0, "mstatus_clear");
    csr_op(OP_RW, MTVEC, 32'h0000_1003, 5'd3, 32'h0000_0100, "mtvec_write");
    csr_read(MTVEC, 32'h0000_1001, "mtvec_bit1");
    csr_op(OP_RW, MIE, 32'hFFFF_FFFF, 5'd3, 32'd0, "mie_write");
    csr_op(OP_RW, MIE, 32'h0000_0880, 5'd3, 32'h000F_0880, "mie_mask");
    csr_op(OP_RSI, MSTATUS, 32'h8, 5'd3, 32'd0, "mie_enable");

    // External and timer pending together: MEI wins, vectored to base + 4*11.
    i_ext_irq = 1'b1; i_timer_irq = 1'b1;
    idle(1, 1'b0);
    trap_req(32'h200, OP_NONE, 12'h0, 32'h0, 5'd0, 32'h0000_102C, "trap_mei");
    csr_read(MCAUSE, 32'h8000_000B, "mcause_mei");
    csr_read(MSTATUS, 32'h0000_0080, "mstatus_after_trap");
    csr_read(MEPC, 32'h0000_0200, "mepc_mei");
    csr_read(MIP, 32'h0000_0880, "mip_ext_timer");
    i_ext_irq = 1'b0;
    trap_req(32'h300, OP_MRET, 12'h0, 32'h0, 5'd0, 32'h0000_0200, "mret");
    trap_req(32'h204, OP_RW, MSCRATCH, 32'h1111_1111, 5'd9, 32'h0000_101C, "trap_mti");
    csr_read(MCAUSE, 32'h8000_0007, "mcause_mti");
    csr_read(MEPC, 32'h0000_0204, "mepc_mti");
    csr_read(MSTATUS, 32'h0000_0080, "mstatus_mti");
    csr_read(MSCRATCH, 32'hDEAD_FFF0, "trapped_csr_not_done");
    i_timer_irq = 1'b0;

    csr_write_nc(MCYCLE, 32'hFFFF_FFFF, "mcycle_set");
    idle(2, 1'b0);
    csr_read(MCYCLEH, 32'd1, "mcycleh_carry");
    csr_write_nc(MINSTRET, 32'h100, "minstret_set");
    idle(5, 1'b1);
    csr_read(MINSTRET, 32'h105, "minstret_plus5");
    csr_read(MINSTRETH, 32'd0, "minstreth");
    apply_stimulus(1'b1, OP_RW, MINSTRET, 32'h200, 5'd0, 5'd10, 32'h0, 1'b1,
                   e_rd(5'd10, 32'h105), "minstret_write_retire");
    csr_read(MINSTRET, 32'h200, "minstret_inc_lost");
    csr_write_nc(MCYCLE, 32'h10, "mcycle_small");
    csr_read(MCYCLE, 32'h10, "mcycle_inc_lost");
    csr_write_nc(MCYCLEH, 32'hFFFF_FFFF, "mcycleh_set");
    csr_write_nc(MCYCLE, 32'hFFFF_FFFE, "mcycle_near_wrap");
    idle(2, 1'b0);
    csr_read(MCYCLE, 32'd0, "mcycle_wrap_lo");
    csr_read(MCYCLEH, 32'd0, "mcycle_wrap_hi");

    csr_op(OP_RW, MIE, 32'h0004_0000, 5'd3, 32'h0000_0880, "mie_local2");
    i_irq = 4'b0100;
    idle(1, 1'b0);
    csr_read(MIP, 32'h0004_0000, "mip_local2_no_trap");
    csr_op(OP_RSI, MSTATUS, 32'h8, 5'd3, 32'h0000_0080, "mie_enable2");
    trap_req(32'h400, OP_NONE, 12'h0, 32'h0, 5'd0, 32'h0000_1048, "trap_local2");
    csr_read(MCAUSE, 32'h8000_0012, "mcause_local2");
    csr_op(OP_RW, MIE, 32'h000F_0000, 5'd3, 32'h0004_0000, "mie_local_all");
    i_irq = 4'b1010;
    idle(1, 1'b0);
    csr_op(OP_RSI, MSTATUS, 32'h8, 5'd3, 32'h0000_0080, "mie_enable3");
    trap_req(32'h404, OP_NONE, 12'h0, 32'h0, 5'd0, 32'h0000_1044, "trap_local_prio");
    csr_read(MCAUSE, 32'h8000_0011, "mcause_local1");
    csr_op(OP_RW, MTVEC, 32'h0000_2000, 5'd3, 32'h0000_1001, "mtvec_direct");
    csr_op(OP_RSI, MSTATUS, 32'h8, 5'd3, 32'h0000_0080, "mie_enable4");
    trap_req(32'h408, OP_NONE, 12'h0, 32'h0, 5'd0, 32'h0000_2000, "trap_direct");
    csr_read(MEPC, 32'h0000_0408, "mepc_direct");
    i_irq = 4'd0;
    idle(2, 1'b0);

    @(negedge clk); #1;
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // Asynchronous reset must drop a result that is already on the outputs.
    @(negedge clk); #1;
    i_request = 1'b1; i_op = OP_RS; i_addr = MISA; i_rs1 = 32'd0; i_inst_rd = 5'd3;
    @(posedge clk); #2;
    check_output("pre_reset.ready", 32'(o_ready), 32'd1);
    check_output("pre_reset.rd", o_rd, 32'h4000_0100);
    i_request = 1'b0;
    i_reset = 1'b0;
    #1;
    check_output("async_reset.ready", 32'(o_ready), 32'd0);
    check_output("async_reset.rd", o_rd, 32'd0);
    check_output("async_reset.inst_rd", 32'(o_inst_rd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
